tabla_sweep_ctrl: RTL

Sequencer that exercises one mux-based truth-table implementation (the t1m2-style 2:1/4:1/8:1 function blocks) in hardware. On `start` it walks the select inputs through every row 0..2^N_IN−1, waits a programmable settle time per row, and captures the function output into a result vector. Optionally compares the vector against an expected truth table. It replaces the hand-written stimulus sequence in the lab benches with a synthesizable, on-board self-check.

---
 rtl/tabla_sweep_ctrl_if.sv | 41 ++++
 rtl/tabla_sweep_ctrl.sv | 123 ++++++++++++
 2 files changed

// File: rtl/tabla_sweep_ctrl_if.sv
// Bus between the sweep sequencer and its user: control, function-block drive/sense, result.
// The slave modport is the sequencer's view; master is the view of whoever drives start.
interface tabla_sweep_ctrl_if #(
    parameter int unsigned N_IN = 3
) ();
    localparam int unsigned ROWS = 1 << N_IN;

    logic              start;
    logic [N_IN-1:0]   abc;
    logic              y;
    logic              busy;
    logic              done;
    logic [ROWS-1:0]   result;
    logic [ROWS-1:0]   expected;
    logic              mismatch;
    logic [N_IN-1:0]   err_row;

    modport slave (
        input  start,
        input  y,
        input  expected,
        output abc,
        output busy,
        output done,
        output result,
        output mismatch,
        output err_row
    );

    modport master (
        output start,
        output y,
        output expected,
        input  abc,
        input  busy,
        input  done,
        input  result,
        input  mismatch,
        input  err_row
    );
endinterface

// File: rtl/tabla_sweep_ctrl.sv
// Walks a truth-table block through every row, captures y per row into result.
// Define TABLA_SWEEP_COMPARE_EN to build the result-vs-expected compare (mismatch/err_row).
module tabla_sweep_ctrl #(
    parameter int unsigned N_IN   = 3,
    parameter int unsigned SETTLE = 1
) (
    input logic               clk,
    input logic               reset,
    tabla_sweep_ctrl_if.slave bus
);
    localparam int unsigned   ROWS     = 1 << N_IN;
    localparam logic [N_IN:0] ROW_LAST = (N_IN + 1)'(ROWS - 1);
    localparam logic [3:0]    SETTLE_W = 4'(SETTLE);

    typedef enum logic [1:0] {StIdle, StDrive, StSample, StFinish} state_e;

    state_e          state_q, state_d;
    logic [N_IN:0]   row_q, row_d;
    logic [3:0]      settle_q, settle_d;
    logic [ROWS-1:0] result_q, result_d;
    logic            cmp_clear;
    logic            cmp_load;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            row_q    <= '0;
            settle_q <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            settle_q <= settle_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        settle_d  = settle_q;
        result_d  = result_q;
        cmp_clear = 1'b0;
        cmp_load  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d   = StDrive;
                    row_d     = '0;
                    settle_d  = SETTLE_W;
                    result_d  = '0;
                    cmp_clear = 1'b1;
                end
            end
            StDrive: begin
                settle_d = settle_q - 4'd1;
                // <= guards against a zero count ever stalling the sweep
                if (settle_q <= 4'd1) begin
                    state_d = StSample;
                end
            end
            StSample: begin
                result_d[row_q[N_IN-1:0]] = bus.y;
                if (row_q == ROW_LAST) begin
                    state_d  = StFinish;
                    cmp_load = 1'b1;
                end else begin
                    row_d    = row_q + (N_IN + 1)'(1);
                    settle_d = SETTLE_W;
                    state_d  = StDrive;
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.busy   = (state_q == StDrive) || (state_q == StSample);
    assign bus.done   = (state_q == StFinish);
    assign bus.abc    = bus.busy ? row_q[N_IN-1:0] : '0;
    assign bus.result = result_q;

`ifdef TABLA_SWEEP_COMPARE_EN
    logic [ROWS-1:0] diff;
    logic [N_IN-1:0] err_row_d;
    logic            mismatch_q;
    logic [N_IN-1:0] err_row_q;

    // Compare against result_d so the last captured row counts and the outputs are valid in FINISH
    assign diff = result_d ^ bus.expected;

    always_comb begin
        err_row_d = '0;
        for (int r = int'(ROWS) - 1; r >= 0; r--) begin
            if (diff[r]) begin
                err_row_d = N_IN'(r);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || cmp_clear) begin
            mismatch_q <= 1'b0;
            err_row_q  <= '0;
        end else if (cmp_load) begin
            mismatch_q <= |diff;
            err_row_q  <= err_row_d;
        end
    end

    assign bus.mismatch = mismatch_q;
    assign bus.err_row  = err_row_q;
`else
    logic unused_cmp;
    assign unused_cmp   = ^{bus.expected, cmp_clear, cmp_load};
    assign bus.mismatch = 1'b0;
    assign bus.err_row  = '0;
`endif
endmodule
